// File: rtl/uart_apb_pkg.sv
// Shared definitions for the UART-facing APB requester:
// FSM encoding, timeout default and UART register map.
package uart_apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

  localparam int DEFAULT_TIMEOUT = 64;
  localparam int TIMER_W         = 8;

  localparam logic [31:0] UART_TX_DATA_ADDR = 32'h0000_0000;
  localparam logic [31:0] UART_RX_DATA_ADDR = 32'h0000_0004;

endpackage

// File: rtl/apb_wait_timer.sv
// Counts ACCESS wait cycles; expired flags the last permitted wait cycle.
module apb_wait_timer
  import uart_apb_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic PCLK,
  input  logic PRESETn,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [TIMER_W-1:0] count_q;
  logic [TIMER_W-1:0] count_d;

  assign expired = (count_q == TIMER_W'(TIMEOUT - 1));

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !expired) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_apb_master.sv
// Single-outstanding APB requester driven by a valid/ready command port,
// with a bounded PREADY wait and a held response.
module uart_apb_master
  import uart_apb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_error,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  output logic              PWRITE,
  output logic              PSELx,
  output logic              PENABLE,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY
);

  apb_state_e        state_q, state_d;
  logic              launch_q, launch_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              pwrite_q, pwrite_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_error_q, rsp_error_d;

  logic timer_clear;
  logic timer_enable;
  logic timer_expired;

  apb_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .clear   (timer_clear),
    .enable  (timer_enable),
    .expired (timer_expired)
  );

  always_comb begin
    state_d      = state_q;
    launch_d     = launch_q;
    paddr_d      = paddr_q;
    pwdata_d     = pwdata_q;
    pwrite_d     = pwrite_q;
    psel_d       = psel_q;
    penable_d    = penable_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_error_d  = rsp_error_q;
    timer_clear  = 1'b0;
    timer_enable = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // Accepted command spends one cycle latched in IDLE before SETUP.
        if (launch_q) begin
          launch_d = 1'b0;
          psel_d   = 1'b1;
          state_d  = ST_SETUP;
        end else if (cmd_valid && cmd_ready_q) begin
          paddr_d  = cmd_addr;
          pwdata_d = cmd_wdata;
          pwrite_d = cmd_write;
          launch_d = 1'b1;
        end
      end
      ST_SETUP: begin
        penable_d   = 1'b1;
        timer_clear = 1'b1;
        state_d     = ST_ACCESS;
      end
      ST_ACCESS: begin
        timer_enable = !PREADY;
        if (PREADY) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_error_d = 1'b0;
          rsp_rdata_d = pwrite_q ? '0 : PRDATA;
          state_d     = ST_RESP;
        end else if (timer_expired) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_error_d = 1'b1;
          rsp_rdata_d = '0;
          state_d     = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    cmd_ready_d = (state_d == ST_IDLE) && !launch_d;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= ST_IDLE;
      launch_q    <= 1'b0;
      cmd_ready_q <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pwrite_q    <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      launch_q    <= launch_d;
      cmd_ready_q <= cmd_ready_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pwrite_q    <= pwrite_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign PWRITE    = pwrite_q;
  assign PSELx     = psel_q;
  assign PENABLE   = penable_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_error = rsp_error_q;

endmodule

// File: tb/tb_uart_apb_master.sv
// Directed and randomized transfers against a transfer-level model of the
// APB requester (latency, wait/timeout outcome, response data).
module tb_uart_apb_master;

  localparam int TO = 8;

  logic        PCLK;
  logic        PRESETn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE;
  logic        PSELx;
  logic        PENABLE;
  logic [31:0] PRDATA;
  logic        PREADY;

  int vectors     = 0;
  int miscompares = 0;
  int cyc_cnt     = 0;
  int last_accept = 0;

  uart_apb_master #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (TO)
  ) dut (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_error (rsp_error),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PWRITE    (PWRITE),
    .PSELx     (PSELx),
    .PENABLE   (PENABLE),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  always @(posedge PCLK) cyc_cnt <= cyc_cnt + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=no_finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  // One transfer: 'waits' ACCESS cycles with PREADY=0 before PREADY=1.
  task automatic do_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input int waits, input logic [31:0] prdata, input int hold,
                         input bit chk_tput);
    int          exp_access;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          cyc;
    int          n_setup;
    int          n_access;
    bit          done;

    if (waits < TO) begin
      exp_access = waits + 1;
      exp_err    = 1'b0;
      exp_rdata  = wr ? 32'h0 : prdata;
    end else begin
      exp_access = TO;
      exp_err    = 1'b1;
      exp_rdata  = 32'h0;
    end

    check("idle_cmd_ready", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    PREADY    = 1'b0;
    PRDATA    = $urandom;
    tick();
    if (chk_tput) check("b2b_period", 65'(cyc_cnt - last_accept), 5);
    last_accept = cyc_cnt;
    check("accept_ready_drop", cmd_ready, 0);

    // Stray commands while busy must be ignored.
    cmd_valid = 1'($urandom_range(0, 1));
    cmd_write = ~wr;
    cmd_addr  = $urandom;
    cmd_wdata = $urandom;

    cyc = 1; n_setup = 0; n_access = 0; done = 1'b0;
    while (!done && cyc < 300) begin
      tick();
      cyc++;
      if (rsp_valid === 1'b1) begin
        done = 1'b1;
      end else if (PSELx === 1'b1) begin
        if (PENABLE === 1'b1) n_access++;
        else n_setup++;
        check("paddr_stable", PADDR, addr);
        check("pwdata_stable", PWDATA, wdata);
        check("pwrite_stable", PWRITE, wr);
        if (PENABLE === 1'b1 && n_access > waits) begin
          PREADY = 1'b1;
          PRDATA = prdata;
        end else begin
          PREADY = 1'b0;
          PRDATA = $urandom;
        end
      end
    end
    PREADY    = 1'b0;
    PRDATA    = $urandom;
    cmd_valid = 1'b0;

    check("rsp_seen", done, 1);
    check("latency", 65'(cyc), 65'(3 + exp_access));
    check("setup_cycles", 65'(n_setup), 1);
    check("access_cycles", 65'(n_access), 65'(exp_access));
    check("rsp_error", rsp_error, exp_err);
    check("rsp_rdata", rsp_rdata, exp_rdata);
    check("resp_psel", {PSELx, PENABLE}, 0);

    rsp_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      tick();
      check("hold_fields", {rsp_valid, rsp_error, rsp_rdata}, {1'b1, exp_err, exp_rdata});
      check("hold_bus", {cmd_ready, PSELx, PENABLE}, 0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("rsp_cleared", rsp_valid, 0);
    check("back_to_idle", cmd_ready, 1);
    $display("xfer wr=%0d addr=%08h waits=%0d hold=%0d -> err=%0d rdata=%08h lat=%0d acc=%0d",
             wr, addr, waits, hold, rsp_error, rsp_rdata, cyc, n_access);
  endtask

  initial begin
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b0;
    PRDATA    = '0;
    PREADY    = 1'b0;
    PRESETn   = 1'b1;
    #1 PRESETn = 1'b0;
    #1;
    check("reset_outputs",
          {cmd_ready, rsp_valid, rsp_error, PWRITE, PSELx, PENABLE}, 0);
    check("reset_data", {rsp_rdata, PADDR}, 0);
    check("reset_pwdata", PWDATA, 0);
    repeat (3) @(posedge PCLK);
    #1;
    check("in_reset_ready", cmd_ready, 0);
    @(negedge PCLK);
    PRESETn = 1'b1;
    tick();
    check("ready_after_reset", cmd_ready, 1);

    // Zero-wait write, then back-to-back zero-wait read.
    do_xfer(1'b1, 32'h0000_0000, 32'h0000_00A5, 0, $urandom, 0, 1'b0);
    do_xfer(1'b0, 32'h0000_0008, $urandom, 0, 32'hCAFE_0001, 0, 1'b1);
    // Read with three wait states.
    do_xfer(1'b0, 32'h0000_0004, 32'h0, 3, 32'h0000_003C, 1, 1'b0);
    // Timeout with PREADY held low.
    do_xfer(1'b0, 32'h0000_0010, 32'h0, 1000, 32'h1234_5678, 1, 1'b0);
    // PREADY on the timeout cycle wins.
    do_xfer(1'b0, 32'h0000_0014, 32'h0, TO - 1, 32'h0000_0055, 0, 1'b0);
    // Ten cycles of response backpressure.
    do_xfer(1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 2, $urandom, 10, 1'b0);

    for (int n = 0; n < 16; n++) begin
      do_xfer(1'($urandom_range(0, 1)), {$urandom_range(0, 32'h3FFF_FFFF), 2'b00},
              $urandom, int'($urandom_range(0, 10)), $urandom,
              int'($urandom_range(0, 2)), 1'b0);
    end

    // Reset asserted between edges during ACCESS.
    check("pre_reset_ready", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 32'h0000_0030;
    cmd_wdata = 32'h0000_0077;
    PREADY    = 1'b0;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    check("mid_reset_in_access", {PSELx, PENABLE}, 2'b11);
    #2 PRESETn = 1'b0;
    #1;
    check("mid_reset_bus_drop", {PSELx, PENABLE}, 0);
    check("mid_reset_no_rsp", {rsp_valid, cmd_ready}, 0);
    repeat (2) tick();
    check("mid_reset_held", {rsp_valid, PSELx, PENABLE}, 0);
    @(negedge PCLK);
    PRESETn = 1'b1;
    tick();
    check("post_reset_ready", cmd_ready, 1);
    do_xfer(1'b1, 32'h0000_0000, 32'h0000_0042, 1, $urandom, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_apb_master.md
UART_APB_MASTER -- requirements
Module: uart_apb_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, APB address width.
REQ-002 SHALL have parameter DATA_W, default 32, APB data width.
REQ-003 SHALL have parameter TIMEOUT, default 64, max ACCESS cycles waiting for PREADY (range 2..255).
REQ-004 SHALL have one clock and an asynchronous, active-low reset. Ports: PCLK (in, 1, clock) and PRESETn (in, 1, reset).
REQ-005 SHALL have port cmd_valid  in  1  command request.
REQ-006 SHALL have port cmd_ready  out  1  command accepted this cycle.
REQ-007 SHALL have port cmd_write  in  1  1=write, 0=read.
REQ-008 SHALL have port cmd_addr  in  ADDR_W  target address.
REQ-009 SHALL have port cmd_wdata  in  DATA_W  write data.
REQ-010 SHALL have port rsp_valid  out  1  response available.
REQ-011 SHALL have port rsp_ready  in  1  response consumed.
REQ-012 SHALL have port rsp_rdata  out  DATA_W  read data (0 for writes and errors).
REQ-013 SHALL have port rsp_error  out  1  transfer timed out.
REQ-014 SHALL have the APB requester ports PADDR (out, ADDR_W), PWDATA (out, DATA_W), PWRITE (out, 1), PSELx (out, 1), PENABLE (out, 1), PRDATA (in, DATA_W) and PREADY (in, 1).

Function
REQ-015 SHALL implement the FSM states IDLE, SETUP, ACCESS and RESP. All outputs SHALL be registered.
REQ-016 SHALL drive cmd_ready=1 only in IDLE. A command is accepted on a rising edge when cmd_valid and cmd_ready are both 1.
REQ-017 On acceptance, the block SHALL latch cmd_addr, cmd_wdata and cmd_write into PADDR, PWDATA and PWRITE, and enter SETUP on the next cycle.
REQ-018 In SETUP, the block SHALL drive PSELx=1 and PENABLE=0 for exactly one cycle, then enter ACCESS.
REQ-019 In ACCESS, the block SHALL drive PSELx=1 and PENABLE=1. PADDR, PWDATA and PWRITE SHALL remain stable from SETUP until ACCESS ends.
REQ-020 In ACCESS, when PREADY=1 is sampled, the block SHALL capture PRDATA (reads only), drop PSELx and PENABLE to 0, and enter RESP with rsp_valid=1 and rsp_error=0.
REQ-021 A wait counter SHALL start at 0 on ACCESS entry and increment for each ACCESS cycle with PREADY=0.
- When the counter reaches TIMEOUT-1 with PREADY=0, the block SHALL abort: PSELx=0, PENABLE=0, RESP with rsp_error=1 and rsp_rdata=0.
REQ-022 If PREADY=1 coincides with the timeout cycle, PREADY SHALL win: normal completion, rsp_error=0.
REQ-023 In RESP, rsp_valid, rsp_rdata and rsp_error SHALL hold until rsp_ready=1. The block SHALL then clear rsp_valid and return to IDLE.
REQ-024 Minimum transfer latency SHALL be 4 cycles, from acceptance edge to rsp_valid, with zero PREADY wait states. Back-to-back throughput SHALL be one transfer per 5 cycles.
REQ-025 For writes, rsp_rdata SHALL be 0.
REQ-026 PRDATA SHALL be ignored outside the PREADY completion edge.
REQ-027 cmd_valid asserted outside IDLE SHALL be ignored, with no queueing.

Reset
REQ-028 PRESETn=0 SHALL asynchronously force state IDLE and set all of the following to 0: PSELx, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_error and the wait counter. cmd_ready SHALL be 0 while in reset.
REQ-029 Reset mid-transfer SHALL drop PSELx and PENABLE immediately, without waiting for a clock edge, and discard the transfer.
REQ-030 After PRESETn deassertion, cmd_ready SHALL be 1 from the first rising edge.

Structure
REQ-031 The FSM state encoding and the default TIMEOUT value SHALL live in shared package uart_apb_pkg, alongside the UART register address constants (TX data, RX data).
REQ-032 The wait counter SHALL be the single sub-module apb_wait_timer, with inputs clear/enable and output expired.

Verification
REQ-033 Write with no wait states: cmd write addr=0x0000_0000, wdata=0x0000_00A5, PREADY tied 1.
- Required: one SETUP cycle then one ACCESS cycle, PWDATA=0xA5 stable throughout.
- Required: rsp_valid 4 cycles after acceptance, rsp_error=0, rsp_rdata=0.
REQ-034 Read with wait states: read addr=0x4, PRDATA=0x0000_003C, PREADY low for 3 ACCESS cycles then high.
- Required: ACCESS lasts 4 cycles, rsp_rdata=0x3C, rsp_error=0.
REQ-035 Timeout: TIMEOUT=8, PREADY held 0.
- Required: PSELx and PENABLE drop after 8 ACCESS cycles; rsp_valid=1, rsp_error=1, rsp_rdata=0.
REQ-036 Timeout coincidence: TIMEOUT=8, PREADY=1 on the 8th ACCESS cycle with PRDATA=0x55.
- Required: rsp_error=0, rsp_rdata=0x55.
REQ-037 Response backpressure: rsp_ready held 0 for 10 cycles after rsp_valid.
- Required: response fields stable, cmd_ready=0, PSELx=0 throughout; IDLE on the cycle after rsp_ready=1.
REQ-038 Reset mid-ACCESS: PRESETn pulled low between clock edges.
- Required: PSELx and PENABLE go 0 immediately, no rsp_valid; after release, cmd_ready=1 and the next write completes normally.
